rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 18 +
 rtl/rf_write_arbiter.sv | 90 +++++++++
 tb/tb_rf_write_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-back path.
// Holds address/data widths, counter width and requester ids.
package rf_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int RF_ADDR_W  = 32;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 16;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

    function automatic logic [RF_ADDR_W-1:0] zext_addr(
        input logic [REG_ADDR_W-1:0] a
    );
        return {{(RF_ADDR_W-REG_ADDR_W){1'b0}}, a};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last.
// Ports: valid0/valid1 requests, last_grant pointer, grant0/grant1 one-hot.
import rf_ctrl_pkg::*;

module rr_arbiter2 (
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    output logic    grant0,
    output logic    grant1
);

    always_comb begin
        grant0 = valid0 & (~valid1 | (last_grant == REQ_MEM));
        grant1 = valid1 & (~valid0 | (last_grant == REQ_ALU));
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-back arbiter with pending-write scoreboard.
// Ports: ALU/MEM write handshakes, registered RF write port, issue/query
// scoreboard interface, saturating contention counter.
import rf_ctrl_pkg::*;

module rf_write_arbiter (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [REG_ADDR_W-1:0] req0_addr,
    input  logic [REG_DATA_W-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [REG_ADDR_W-1:0] req1_addr,
    input  logic [REG_DATA_W-1:0] req1_data,
    output logic                  writeEnable,
    output logic [RF_ADDR_W-1:0]  addressWrite,
    output logic [REG_DATA_W-1:0] dataWrite,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic [REG_ADDR_W-1:0] query_a_addr,
    input  logic [REG_ADDR_W-1:0] query_b_addr,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic [CNT_W-1:0]      contention_cnt
);

    req_id_t               last_grant;
    logic                  gnt0;
    logic                  gnt1;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] xfer_addr;
    logic [REG_DATA_W-1:0] xfer_data;
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;

    rr_arbiter2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant0     (gnt0),
        .grant1     (gnt1)
    );

    // Ready is suppressed combinationally while reset is held.
    assign req0_ready = gnt0 & rst;
    assign req1_ready = gnt1 & rst;

    // A grant implies valid, so ready alone marks a transfer.
    assign xfer      = req0_ready | req1_ready;
    assign xfer_addr = req1_ready ? req1_addr : req0_addr;
    assign xfer_data = req1_ready ? req1_data : req0_data;

    // Clear on write-back first, then set on issue so a same-cycle
    // issue to the same register keeps it pending.
    always_comb begin
        pending_next = pending;
        if (xfer && (xfer_addr != '0))
            pending_next[xfer_addr] = 1'b0;
        if (issue_valid && (issue_addr != '0))
            pending_next[issue_addr] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeEnable    <= 1'b0;
            addressWrite   <= '0;
            dataWrite      <= '0;
            last_grant     <= REQ_MEM;
            pending        <= '0;
            contention_cnt <= '0;
        end else begin
            writeEnable <= xfer && (xfer_addr != '0);
            if (xfer) begin
                addressWrite <= zext_addr(xfer_addr);
                dataWrite    <= xfer_data;
                last_grant   <= req1_ready ? REQ_MEM : REQ_ALU;
            end
            pending <= pending_next;
            if (req0_valid && req1_valid && (contention_cnt != '1))
                contention_cnt <= contention_cnt + 1'b1;
        end
    end

    assign busy_a = pending[query_a_addr];
    assign busy_b = pending[query_b_addr];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table, hand sequences,
// random traffic against a behavioural model, reset and saturation cases.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        writeEnable;
    logic [31:0] addressWrite, dataWrite;
    logic        issue_valid;
    logic [4:0]  issue_addr, query_a_addr, query_b_addr;
    logic        busy_a, busy_b;
    logic [15:0] contention_cnt;

    int n_chk = 0;
    int n_pass = 0;

    // behavioural model state
    bit          m_last;
    bit [31:0]   m_pend;
    int          m_cnt;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .writeEnable    (writeEnable),
        .addressWrite   (addressWrite),
        .dataWrite      (dataWrite),
        .issue_valid    (issue_valid),
        .issue_addr     (issue_addr),
        .query_a_addr   (query_a_addr),
        .query_b_addr   (query_b_addr),
        .busy_a         (busy_a),
        .busy_b         (busy_b),
        .contention_cnt (contention_cnt)
    );

    typedef struct {
        bit          v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        bit          v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        bit          r0;
        bit          r1;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_pend = '0;
        m_cnt  = 0;
        m_we   = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        issue_valid = 0; issue_addr = 0;
        query_a_addr = 0; query_b_addr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        req0_valid = 1;
        req1_valid = 1;
        @(posedge clk); #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_we", writeEnable, 0);
        chk("rst_wa", addressWrite, 0);
        chk("rst_wd", dataWrite, 0);
        chk("rst_cnt", contention_cnt, 0);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive, check combinational outputs at negedge,
    // advance the model at the edge, check registered outputs after it.
    task automatic cycle(
        input bit v0, input logic [4:0] a0, input logic [31:0] d0,
        input bit v1, input logic [4:0] a1, input logic [31:0] d1,
        input bit iv, input logic [4:0] ia,
        input logic [4:0] qa, input logic [4:0] qb,
        output bit r0s, output bit r1s, output bit ba, output bit bb
    );
        int g;
        logic [4:0]  ga;
        logic [31:0] gd;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        issue_valid = iv; issue_addr = ia;
        query_a_addr = qa; query_b_addr = qb;
        @(negedge clk);
        if (v0 && v1) g = m_last ? 0 : 1;
        else if (v0) g = 0;
        else if (v1) g = 1;
        else g = -1;
        r0s = req0_ready; r1s = req1_ready;
        ba = busy_a; bb = busy_b;
        chk("ready0", r0s, g == 0);
        chk("ready1", r1s, g == 1);
        chk("busy_a", ba, m_pend[qa]);
        chk("busy_b", bb, m_pend[qb]);
        chk("cnt", contention_cnt, m_cnt);
        @(posedge clk); #1;
        ga = (g == 1) ? a1 : a0;
        gd = (g == 1) ? d1 : d0;
        m_we = (g >= 0) && (ga != 0);
        if (g >= 0) begin
            m_wa = ga;
            m_wd = gd;
            m_last = (g == 1);
            if (ga != 0) m_pend[ga] = 1'b0;
        end
        if (iv && ia != 0) m_pend[ia] = 1'b1;
        if (v0 && v1 && m_cnt < 65535) m_cnt++;
        chk("we", writeEnable, m_we);
        if (m_we) begin
            chk("wa", addressWrite, {27'b0, m_wa});
            chk("wd", dataWrite, m_wd);
        end
    endtask

    initial begin
        bit r0s, r1s, ba, bb;
        rst = 1'b0;
        idle_inputs();
        model_reset();

        vecs[0] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11};
        vecs[1] = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1, 2, 32'h22};
        vecs[2] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 1, 32'h11};
        vecs[3] = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1, 2, 32'h22};
        vecs[4] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0};
        vecs[5] = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,
                    1, 0, 1, 5, 32'hDEADBEEF};
        vecs[6] = '{0, 0, 32'h0, 1, 0, 32'h33, 0, 1, 0, 0, 32'h0};
        vecs[7] = '{1, 0, 32'h44, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0};
        vecs[8] = '{1, 3, 32'h55, 1, 4, 32'h66, 0, 1, 1, 4, 32'h66};
        vecs[9] = '{1, 3, 32'h55, 1, 4, 32'h66, 1, 0, 1, 3, 32'h55};

        do_reset();

        // first write straight after reset release
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, r0s, r1s, ba, bb);
        chk("first_ready0", r0s, 1);
        chk("first_we", writeEnable, 1);
        chk("first_wa", addressWrite, 5);
        chk("first_wd", dataWrite, 32'hDEADBEEF);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].v0, vecs[i].a0, vecs[i].d0,
                  vecs[i].v1, vecs[i].a1, vecs[i].d1,
                  0, 0, 0, 0, r0s, r1s, ba, bb);
            chk($sformatf("vec%0d_r0", i), r0s, vecs[i].r0);
            chk($sformatf("vec%0d_r1", i), r1s, vecs[i].r1);
            chk($sformatf("vec%0d_we", i), writeEnable, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_wa", i), addressWrite,
                    {27'b0, vecs[i].wa});
                chk($sformatf("vec%0d_wd", i), dataWrite, vecs[i].wd);
            end
            if (i == 3) chk("cnt_after_4", contention_cnt, 4);
        end
        chk("cnt_after_table", contention_cnt, 6);

        // scoreboard: issue then clear by load write-back
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, r0s, r1s, ba, bb);
        cycle(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0, r0s, r1s, ba, bb);
        chk("sb_busy7_set", ba, 1);
        chk("sb_ready1", r1s, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, r0s, r1s, ba, bb);
        chk("sb_busy7_clr", ba, 0);

        // set wins over same-cycle clear
        cycle(1, 9, 32'h99, 0, 0, 0, 1, 9, 0, 9, r0s, r1s, ba, bb);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, r0s, r1s, ba, bb);
        chk("sb_busy9_kept", bb, 1);

        // register 0 write and issue
        cycle(1, 0, 32'hAB, 0, 0, 0, 1, 0, 0, 0, r0s, r1s, ba, bb);
        chk("r0_ready", r0s, 1);
        chk("r0_we", writeEnable, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0s, r1s, ba, bb);
        chk("r0_busy", ba, 0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  r0s, r1s, ba, bb);
        end

        // reset in the middle of an accepted transfer
        cycle(1, 6, 32'h1234, 0, 0, 0, 1, 6, 6, 0, r0s, r1s, ba, bb);
        req0_valid = 1; req0_addr = 6; req0_data = 32'h5678;
        req1_valid = 0;
        issue_valid = 0;
        #2;
        chk("mid_ready_pre", req0_ready, 1);
        rst = 1'b0;
        #1;
        chk("mid_ready0", req0_ready, 0);
        chk("mid_we", writeEnable, 0);
        chk("mid_wa", addressWrite, 0);
        chk("mid_wd", dataWrite, 0);
        chk("mid_cnt", contention_cnt, 0);
        chk("mid_busy", busy_a, 0);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_rst_we", writeEnable, 0);
        end

        // counter saturation
        req0_valid = 1; req0_addr = 1;
        req1_valid = 1; req1_addr = 2;
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt_sat", contention_cnt, 16'hFFFF);
        idle_inputs();
        @(posedge clk); #1;
        chk("cnt_hold", contention_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
